// File: rtl/multicycle_accumulator_cpu.sv
// rtl/multicycle_accumulator_cpu.sv - multi-cycle accumulator CPU with req/valid instruction and data ports
// FETCH/DECODE/MEM/EXEC/HALT sequencer; every output comes straight from a flop.
module multicycle_accumulator_cpu #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned PC_W     = 8,
   parameter int unsigned DADDR_W  = 9,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_valid,
   input  logic [15:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_valid,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               halted,
   output logic [DATA_W-1:0]  acc,
   output logic [PC_W-1:0]    pc,
   output logic [CNT_W-1:0]   retired
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_MEM,
      S_EXEC,
      S_HALT
   } state_e;

   typedef enum logic [2:0] {
      OP_JMP  = 3'b000,
      OP_JRP  = 3'b001,
      OP_LDN  = 3'b010,
      OP_STO  = 3'b011,
      OP_SUBA = 3'b100,
      OP_SUBB = 3'b101,
      OP_CMP  = 3'b110,
      OP_STP  = 3'b111
   } op_e;

   state_e               state_q,      state_d;
   logic [PC_W-1:0]      pc_q,         pc_d;
   logic [DATA_W-1:0]    acc_q,        acc_d;
   logic [15:0]          ir_q,         ir_d;
   logic [DATA_W-1:0]    mdr_q,        mdr_d;
   logic [CNT_W-1:0]     retired_q,    retired_d;
   logic                 halted_q,     halted_d;
   logic                 imem_req_q,   imem_req_d;
   logic                 dmem_req_q,   dmem_req_d;
   logic                 dmem_we_q,    dmem_we_d;
   logic [DADDR_W-1:0]   dmem_addr_q,  dmem_addr_d;
   logic [DATA_W-1:0]    dmem_wdata_q, dmem_wdata_d;

   op_e                  opcode;
   logic                 unused_ir_bits;

   assign opcode         = op_e'(ir_q[15:13]);
   // Operand bits above DADDR_W are architecturally ignored.
   assign unused_ir_bits = ^ir_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      acc_d        = acc_q;
      ir_d         = ir_q;
      mdr_d        = mdr_q;
      retired_d    = retired_q;
      halted_d     = halted_q;
      imem_req_d   = imem_req_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;

      case (state_q)
         S_FETCH: begin
            if (!imem_req_q) begin
               imem_req_d = 1'b1;
            end else if (imem_valid) begin
               imem_req_d = 1'b0;
               ir_d       = imem_rdata;
               pc_d       = pc_q + PC_W'(1);
               state_d    = S_DECODE;
            end
         end

         S_DECODE: begin
            case (opcode)
               OP_STP: begin
                  state_d   = S_HALT;
                  halted_d  = 1'b1;
                  retired_d = retired_q + CNT_W'(1);
               end
               OP_CMP:  state_d = S_EXEC;
               default: state_d = S_MEM;
            endcase
         end

         S_MEM: begin
            // Address, direction and write data are captured once with req and held until valid.
            if (!dmem_req_q) begin
               dmem_req_d   = 1'b1;
               dmem_we_d    = (opcode == OP_STO);
               dmem_addr_d  = ir_q[DADDR_W-1:0];
               dmem_wdata_d = acc_q;
            end else if (dmem_valid) begin
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               mdr_d      = dmem_rdata;
               state_d    = S_EXEC;
            end
         end

         S_EXEC: begin
            case (opcode)
               OP_JMP:  pc_d  = mdr_q[PC_W-1:0];
               OP_JRP:  pc_d  = pc_q + mdr_q[PC_W-1:0];
               OP_LDN:  acc_d = -mdr_q;
               OP_SUBA,
               OP_SUBB: acc_d = acc_q - mdr_q;
               OP_CMP: begin
                  if (acc_q[DATA_W-1]) pc_d = pc_q + PC_W'(1);
               end
               default: ;
            endcase
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
         end

         S_HALT: ;

         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         pc_q         <= PC_W'(RESET_PC);
         acc_q        <= '0;
         ir_q         <= '0;
         mdr_q        <= '0;
         retired_q    <= '0;
         halted_q     <= 1'b0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         acc_q        <= acc_d;
         ir_q         <= ir_d;
         mdr_q        <= mdr_d;
         retired_q    <= retired_d;
         halted_q     <= halted_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign dmem_addr  = dmem_addr_q;
   assign dmem_wdata = dmem_wdata_q;
   assign halted     = halted_q;
   assign acc        = acc_q;
   assign pc         = pc_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_accumulator_cpu.sv
// tb/tb_multicycle_accumulator_cpu.sv - bench for multicycle_accumulator_cpu
// Wait-state memory responders, an ISA-plus-latency reference model and directed programs.
module tb_multicycle_accumulator_cpu;

   localparam int DATA_W  = 32;
   localparam int PC_W    = 8;
   localparam int DADDR_W = 9;
   localparam int CNT_W   = 32;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_valid;
   logic [15:0]        imem_rdata;
   logic               dmem_req;
   logic               dmem_we;
   logic [DADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic               dmem_valid;
   logic [DATA_W-1:0]  dmem_rdata;
   logic               halted;
   logic [DATA_W-1:0]  acc;
   logic [PC_W-1:0]    pc;
   logic [CNT_W-1:0]   retired;

   multicycle_accumulator_cpu #(
      .DATA_W(DATA_W), .PC_W(PC_W), .DADDR_W(DADDR_W), .RESET_PC(0), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
      .halted(halted), .acc(acc), .pc(pc), .retired(retired)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int iwait = 0, dwait = 0;
   bit spur = 0;
   bit chk_en = 0;

   logic [15:0]       imem   [0:255];
   logic [DATA_W-1:0] dmem   [0:511];
   logic [15:0]       m_imem [0:255];
   logic [DATA_W-1:0] m_dmem [0:511];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Memory responders: valid comes iwait/dwait cycles after req is first seen.
   int icnt = 0, dcnt = 0;
   initial begin
      imem_valid = 0; imem_rdata = '0; dmem_valid = 0; dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            if (icnt == iwait) begin
               imem_valid = 1; imem_rdata = imem[imem_addr]; icnt = 0;
            end else begin
               imem_valid = 0; imem_rdata = 16'hE000; icnt++;
            end
         end else begin
            imem_valid = spur; imem_rdata = 16'hE000; icnt = 0;
         end
         if (dmem_req === 1'b1) begin
            if (dcnt == dwait) begin
               dmem_valid = 1; dmem_rdata = dmem[dmem_addr]; dcnt = 0;
               if (dmem_we === 1'b1) dmem[dmem_addr] = dmem_wdata;
            end else begin
               dmem_valid = 0; dmem_rdata = 32'hDEAD_BEEF; dcnt++;
            end
         end else begin
            dmem_valid = spur; dmem_rdata = 32'hDEAD_BEEF; dcnt = 0;
         end
      end
   end

   // Reference model: ISA semantics plus the per-instruction cycle budget.
   logic [PC_W-1:0]   m_pc;
   logic [DATA_W-1:0] m_acc, m_M;
   logic [CNT_W-1:0]  m_ret;
   logic              m_halt;
   logic [15:0]       m_ir;
   int                k, fl, len;
   logic [2:0]        op;

   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            m_pc = '0; m_acc = '0; m_ret = '0; m_halt = 0; m_ir = '0; k = 0;
         end else if (!m_halt) begin
            if (k == 0) m_ir = m_imem[m_pc];
            op = m_ir[15:13];
            fl = 2 + iwait;
            if (k == fl - 1) m_pc = m_pc + 1'b1;
            if (op == 3'd7 && k == fl) begin
               m_halt = 1; m_ret = m_ret + 1'b1; k = 0;
            end else begin
               len = (op == 3'd6) ? fl + 2 : fl + 4 + dwait;
               if (k == len - 1) begin
                  m_M = m_dmem[m_ir[DADDR_W-1:0]];
                  case (op)
                     3'd0: m_pc = m_M[PC_W-1:0];
                     3'd1: m_pc = m_pc + m_M[PC_W-1:0];
                     3'd2: m_acc = -m_M;
                     3'd3: m_dmem[m_ir[DADDR_W-1:0]] = m_acc;
                     3'd4, 3'd5: m_acc = m_acc - m_M;
                     3'd6: if (m_acc[DATA_W-1]) m_pc = m_pc + 1'b1;
                     default: ;
                  endcase
                  m_ret = m_ret + 1'b1; k = 0;
               end else begin
                  k++;
               end
            end
         end
      end
   end

   logic e_ireq, e_dreq;
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            fl = 2 + iwait;
            e_ireq = !m_halt && k >= 1 && k <= fl - 1;
            e_dreq = !m_halt && (m_ir[15:13] < 3'd6) && k >= fl + 2 && k <= fl + 2 + dwait;
            chk("cyc_acc", acc, m_acc);
            chk("cyc_pc", pc, m_pc);
            chk("cyc_retired", retired, m_ret);
            chk("cyc_halted", halted, m_halt);
            chk("cyc_imem_req", imem_req, e_ireq);
            chk("cyc_dmem_req", dmem_req, e_dreq);
            if (e_ireq) chk("cyc_imem_addr", imem_addr, m_pc);
            if (e_dreq) begin
               chk("cyc_dmem_we", dmem_we, m_ir[15:13] == 3'd3);
               chk("cyc_dmem_addr", dmem_addr, m_ir[DADDR_W-1:0]);
               chk("cyc_dmem_wdata", dmem_wdata, m_acc);
            end
         end
      end
   end

   task automatic put_i(input int a, input logic [15:0] v);
      imem[a] = v; m_imem[a] = v;
   endtask

   task automatic put_d(input int a, input logic [DATA_W-1:0] v);
      dmem[a] = v; m_dmem[a] = v;
   endtask

   // Leaves reset asserted with memories cleared; caller loads a program then releases.
   task automatic start_reset(input int iw, input int dw, input bit sp);
      @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      iwait = iw; dwait = dw; spur = sp;
      for (int i = 0; i < 256; i++) begin imem[i] = 16'hE000; m_imem[i] = 16'hE000; end
      for (int i = 0; i < 512; i++) begin dmem[i] = '0; m_dmem[i] = '0; end
   endtask

   task automatic wait_ret(input int n, output int cyc);
      cyc = 0;
      while (retired !== CNT_W'(n) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk("wait_retired", retired, n);
   endtask

   int c, nreq;
   initial begin
      start_reset(0, 0, 0);
      chk_en = 1;
      chk("rst_acc", acc, 0);
      chk("rst_pc", pc, 0);
      chk("rst_retired", retired, 0);
      chk("rst_halted", halted, 0);
      chk("rst_reqs", {imem_req, dmem_req, dmem_we}, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_dmem_wdata", dmem_wdata, 0);

      // Program 1: zero-wait memories, every opcode class, PC wrap.
      put_i(0, 16'h4005); put_i(1, 16'hBE06); put_i(2, 16'h6007); put_i(3, 16'hC000);
      put_i(4, 16'hE000); put_i(5, 16'h4008); put_i(6, 16'hC000); put_i(7, 16'h400B);
      put_i(8, 16'h0001); put_i(16, 16'h2002); put_i(15, 16'h000A); put_i(255, 16'hC000);
      put_d(1, 32'h10); put_d(2, 32'hFFFF_FFFE); put_d(5, 7); put_d(6, 3);
      put_d(8, 32'hFFFF_FFFF); put_d(10, 32'hFF); put_d(11, 5);
      reset = 0;
      wait_ret(1, c);
      chk("ldn_cycles", c, 6);
      chk("ldn_acc", acc, 32'hFFFF_FFF9);
      chk("ldn_pc", pc, 1);
      wait_ret(2, c);
      chk("sub_acc", acc, 32'hFFFF_FFF6);
      c = 0;
      while (!(dmem_req === 1'b1 && dmem_we === 1'b1) && c < 100) begin @(negedge clk); c++; end
      chk("sto_req_we", {dmem_req, dmem_we}, 2'b11);
      chk("sto_addr", dmem_addr, 7);
      chk("sto_wdata", dmem_wdata, 32'hFFFF_FFF6);
      wait_ret(3, c);
      wait_ret(4, c);
      chk("cmp_neg_cycles", c, 4);
      chk("cmp_neg_pc", pc, 5);
      wait_ret(5, c);
      chk("ldn_neg1_acc", acc, 1);
      wait_ret(6, c);
      chk("cmp_pos_pc", pc, 7);
      wait_ret(7, c);
      chk("ldn5_acc", acc, 32'hFFFF_FFFB);
      wait_ret(8, c);
      chk("jmp_pc", pc, 8'h10);
      wait_ret(9, c);
      chk("jrp_pc", pc, 8'h0F);
      wait_ret(10, c);
      chk("jmp_ff_pc", pc, 8'hFF);
      wait_ret(11, c);
      chk("cmp_wrap_pc", pc, 8'h01);
      chk("sto_mem", dmem[7], 32'hFFFF_FFF6);

      // Reset during MEM with dmem_valid arriving in the same cycle.
      start_reset(0, 0, 0);
      put_i(0, 16'h4005); put_i(1, 16'hBE06);
      put_d(5, 7); put_d(6, 3);
      reset = 0;
      wait_ret(1, c);
      c = 0;
      while (dmem_req !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      chk("mem_req_seen", dmem_req, 1);
      reset = 1;
      @(negedge clk);
      chk("rstmem_reqs", {imem_req, dmem_req}, 0);
      chk("rstmem_pc", pc, 0);
      chk("rstmem_acc", acc, 0);
      chk("rstmem_retired", retired, 0);
      reset = 0;
      wait_ret(1, c);
      chk("restart_cycles", c, 6);
      chk("restart_acc", acc, 32'hFFFF_FFF9);

      // Wait states, spurious valids while req is low, then STP.
      start_reset(3, 2, 1);
      put_i(0, 16'h4005); put_i(1, 16'h6007); put_i(2, 16'hE000);
      put_d(5, 7);
      reset = 0;
      wait_ret(1, c);
      chk("wait_ldn_cycles", c, 11);
      chk("wait_ldn_acc", acc, 32'hFFFF_FFF9);
      wait_ret(2, c);
      c = 0;
      while (halted !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      chk("stp_cycles", c, 6);
      chk("stp_halted", halted, 1);
      chk("stp_retired", retired, 3);
      nreq = 0;
      repeat (20) begin
         @(negedge clk);
         if (imem_req !== 1'b0 || dmem_req !== 1'b0) nreq++;
      end
      chk("halt_no_req", nreq, 0);
      chk("halt_retired_held", retired, 3);
      chk("halt_pc_held", pc, 3);
      chk("wait_sto_mem", dmem[7], 32'hFFFF_FFF9);
      start_reset(0, 0, 0);
      chk("rst_clears_halt", halted, 0);
      chk("rst_clears_retired", retired, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
